freq_snapshot_fifo: RTL and testbench
=====================================

Name: freq_snapshot_fifo

Overview:
- Downstream consumer of the multi-channel frequency counter's packed count bus.
- Detects each new, settled measurement on the bus and freezes it as a snapshot.
- Queues each snapshot as NUM_COUNTERS tagged 32-bit words in a FIFO.
- Streams the words out over a valid/ready interface to the AXI register/readout logic, so no measurement is lost or torn between software reads.

Parameters:
- NUM_COUNTERS, 4, number of 32-bit channels on freq_in (1..16).
- STABLE_CYCLES, 4, consecutive identical clk samples required before a changed bus is accepted (>=2).
- FIFO_DEPTH, 32, words of storage; power of two, >= NUM_COUNTERS.

Ports:
- clk  in  1  system clock, 100 MHz.
- aresetn  in  1  asynchronous active-low reset.
- freq_in  in  NUM_COUNTERS*32  packed counts, channel i at [32i+31:32i]; may update on any edge.
- force_capture  in  1  one-cycle pulse: snapshot current settled bus even if unchanged.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts word when m_valid&&m_ready.
- m_data  out  32  channel count.
- m_chan  out  4  channel index of m_data.
- m_last  out  1  high on the final channel word of a snapshot.
- m_seq  out  8  snapshot sequence number, constant across one snapshot.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- drop_count  out  16  snapshots discarded for lack of space, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is aresetn, asynchronous assert, active-low; release is synchronised internally with a 2-flop chain.
- Reset values: m_valid=0, m_data=0, m_chan=0, m_last=0, m_seq=0, fifo_level=0, drop_count=0.
  - FIFO pointers=0, sequence counter=0, stability counter=0, committed snapshot=0, FSM=IDLE.
- Input sampling:
  - freq_in is registered every clk into a sample register.
  - Stability counter resets to 0 when the sample differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
  - The bus is "settled" when stability counter == STABLE_CYCLES.
- Trigger, evaluated only in IDLE, only when settled:
  - Fires if sample != committed snapshot, or if a force_capture is pending.
  - force_capture is latched into a pending flag; the flag clears on trigger.
  - Pulses arriving while not IDLE set the flag and are serviced later.
- On trigger: copy the sample into the snapshot register, update the committed snapshot, go to CHECK.
- FSM states:
  - IDLE: wait for trigger.
  - CHECK (1 cycle): if free space >= NUM_COUNTERS, go to WRITE with channel index k=0. Otherwise increment drop_count (saturate at 0xFFFF), increment the sequence counter, and return to IDLE. A dropped snapshot is never partially written.
  - WRITE: push {seq, k==NUM_COUNTERS-1, k, snapshot[k]} one word per cycle. When k==NUM_COUNTERS-1, increment seq (wraps 255->0) and return to IDLE.
  - Space is reserved in CHECK, so WRITE never stalls and never overflows.
- Trigger-to-first-word latency: 2 clk from trigger cycle to first word in FIFO; m_valid rises 1 clk later if the FIFO was empty.
- Output stage:
  - First-word-fall-through: m_valid=1 whenever fifo_level>0; m_data/m_chan/m_last/m_seq show the head word.
  - Pop on m_valid&&m_ready.
  - Output fields hold stable while m_valid&&!m_ready.
- Simultaneous push and pop in the same cycle: fifo_level unchanged; both take effect.
- Full FIFO: only reachable via reservation accounting; a pop in the same cycle as CHECK is not credited until the next cycle.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- Reset mid-operation: any partially written snapshot is discarded and FIFO contents are lost; state returns to reset values.

Test Plan:
1. Reset, NUM_COUNTERS=4, then hold freq_in={40,30,20,10} (ch3..ch0) with m_ready=1 -> after 4 settle cycles plus latency, 4 words emitted: data 10,20,30,40; chan 0..3; m_last only on chan 3; m_seq=0. Bus then held steady -> no further words.
2. Toggle freq_in every cycle for 20 cycles, then hold {4,3,2,1} -> exactly one snapshot, carrying the final value, with m_seq=1; no snapshot of any intermediate value.
3. m_ready=0; fire force_capture 9 times with FIFO_DEPTH=32 -> 8 snapshots stored (fifo_level=32), drop_count=1. Then set m_ready=1 -> 32 words drain with m_seq 0..7; m_seq 8 (the dropped snapshot) is skipped.
4. m_ready toggling every cycle during a snapshot write -> no word duplicated or lost; fields hold steady while stalled.
5. Assert aresetn=0 mid-WRITE (after 2 of 4 words) -> m_valid=0, fifo_level=0 immediately. After release, the next settled value produces a complete 4-word snapshot with m_seq=0.
6. Issue 300 force_capture snapshots with m_ready=1 -> m_seq wraps 255->0; drop_count stays 0.

Source files
------------

// File: rtl/freq_snapshot_fifo_if.sv
// Readout stream carrying tagged channel words from the snapshot FIFO.
//   m_valid/m_ready : handshake, a word moves when both are high
//   m_data          : channel count
//   m_chan          : channel index of m_data
//   m_last          : final channel word of a snapshot
//   m_seq           : snapshot sequence number
interface freq_snapshot_fifo_if;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [3:0]  m_chan;
   logic        m_last;
   logic [7:0]  m_seq;

   modport master (output m_valid, m_data, m_chan, m_last, m_seq, input m_ready);
   modport slave  (input m_valid, m_data, m_chan, m_last, m_seq, output m_ready);
endinterface

// File: rtl/freq_snapshot_fifo.sv
// Freezes each new, settled value of the frequency counter bus into a
// snapshot and queues it as NUM_COUNTERS tagged words for readout.
//   clk, aresetn   : clock, async active-low reset (release synchronised)
//   freq_in        : packed counts, channel i at [32i+31:32i]
//   force_capture  : pulse, snapshot the settled bus even if unchanged
//   m              : first-word-fall-through output stream
//   fifo_level     : words stored
//   drop_count     : snapshots discarded for lack of space (saturating)
module freq_snapshot_fifo #(
   parameter int NUM_COUNTERS  = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int FIFO_DEPTH    = 32
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic [NUM_COUNTERS*32-1:0]   freq_in,
   input  logic                         force_capture,
   freq_snapshot_fifo_if.master         m,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [15:0]                  drop_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int KW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
   localparam logic [KW-1:0] LAST_K  = KW'(NUM_COUNTERS - 1);
   localparam logic [SW-1:0] STAB_MX = SW'(STABLE_CYCLES);
   localparam logic [AW:0]   MAX_LVL = (AW+1)'(FIFO_DEPTH - NUM_COUNTERS);

   typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

   typedef struct packed {
      logic [7:0]  seq;
      logic        last;
      logic [3:0]  chan;
      logic [31:0] data;
   } word_t;

   logic [1:0]                rst_sync;
   logic                      rst_n;
   logic [NUM_COUNTERS*32-1:0] samp, snap, committed;
   logic [SW-1:0]             stab;
   logic                      settled, pend, trig, push, pop, space_ok;
   state_t                    state, state_n;
   logic [KW-1:0]             k;
   logic [7:0]                seq;
   logic [AW:0]               wptr, rptr;
   word_t                     mem [FIFO_DEPTH];
   word_t                     push_word, head;

   // Assert asynchronously, release two clocks after aresetn rises.
   always_ff @(posedge clk or negedge aresetn)
      if (!aresetn) rst_sync <= '0;
      else          rst_sync <= {rst_sync[0], 1'b1};
   assign rst_n = rst_sync[1];

   // Stability counter restarts whenever the newly sampled value differs
   // from the one already held in samp.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         samp <= '0;
         stab <= '0;
      end else begin
         samp <= freq_in;
         if (freq_in != samp)     stab <= '0;
         else if (stab != STAB_MX) stab <= stab + 1'b1;
      end

   assign settled    = (stab == STAB_MX);
   assign fifo_level = wptr - rptr;
   // Reservation uses the registered level, so a pop in the CHECK cycle
   // only frees space from the following cycle on.
   assign space_ok   = (fifo_level <= MAX_LVL);

   always_comb begin
      state_n = state;
      trig    = 1'b0;
      push    = 1'b0;
      case (state)
         IDLE:  if (settled && (samp != committed || pend)) begin
                   trig    = 1'b1;
                   state_n = CHECK;
                end
         CHECK: state_n = space_ok ? WRITE : IDLE;
         WRITE: begin
                   push = 1'b1;
                   if (k == LAST_K) state_n = IDLE;
                end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         snap       <= '0;
         committed  <= '0;
         pend       <= 1'b0;
         k          <= '0;
         seq        <= '0;
         drop_count <= '0;
      end else begin
         state <= state_n;
         // A pulse landing in the trigger cycle stays pending.
         pend  <= force_capture | (pend & ~trig);
         if (trig) begin
            snap      <= samp;
            committed <= samp;
         end
         case (state)
            CHECK: if (space_ok) k <= '0;
                   else begin
                      seq <= seq + 1'b1;
                      if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
                   end
            WRITE: begin
                      k <= k + 1'b1;
                      if (k == LAST_K) seq <= seq + 1'b1;
                   end
            default: ;
         endcase
      end

   assign push_word = '{seq: seq, last: (k == LAST_K), chan: 4'(k),
                        data: snap[{k, 5'b0} +: 32]};

   always_ff @(posedge clk)
      if (push) mem[wptr[AW-1:0]] <= push_word;

   assign pop = m.m_valid & m.m_ready;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + (AW+1)'(push);
         rptr <= rptr + (AW+1)'(pop);
      end

   // Head word is gated so the stream reads zero while empty.
   assign head      = mem[rptr[AW-1:0]];
   assign m.m_valid = (fifo_level != '0);
   assign m.m_data  = m.m_valid ? head.data : '0;
   assign m.m_chan  = m.m_valid ? head.chan : '0;
   assign m.m_last  = m.m_valid ? head.last : 1'b0;
   assign m.m_seq   = m.m_valid ? head.seq  : '0;
endmodule

// File: tb/tb_freq_snapshot_fifo.sv
module tb_freq_snapshot_fifo;
   localparam int N = 4, SC = 4, D = 32;

   logic            clk = 1'b0;
   logic            aresetn = 1'b0;
   logic            force_capture = 1'b0;
   logic [N*32-1:0] freq_in = '0;
   logic [5:0]      fifo_level;
   logic [15:0]     drop_count;

   freq_snapshot_fifo_if mif();

   always #5 clk = ~clk;

   freq_snapshot_fifo #(.NUM_COUNTERS(N), .STABLE_CYCLES(SC), .FIFO_DEPTH(D)) dut (
      .clk(clk), .aresetn(aresetn), .freq_in(freq_in), .force_capture(force_capture),
      .m(mif), .fifo_level(fifo_level), .drop_count(drop_count));

   int checks = 0, errors = 0;
   logic [44:0] exq[$];
   logic [44:0] rcv[$];
   int rd_idx = 0;
   int hold_bad = 0, hold_cnt = 0;

   // reference model: snapshot rules in terms of whole values
   logic [N*32-1:0] m_committed = '0;
   int m_seq = 0, m_drop = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse();
      force_capture = 1'b1; tick(); force_capture = 1'b0;
   endtask

   task automatic model_snap(input logic [N*32-1:0] v);
      for (int i = 0; i < N; i++)
         exq.push_back({8'(m_seq), (i == N-1), 4'(i), v[32*i +: 32]});
      m_committed = v;
      m_seq = (m_seq + 1) % 256;
   endtask

   task automatic model_value(input logic [N*32-1:0] v);
      if (v != m_committed) model_snap(v);
   endtask

   task automatic drain();
      int quiet = 0, n = 0;
      mif.m_ready = 1'b1;
      while (quiet < 10 && n < 3000) begin
         tick(); n++;
         quiet = (fifo_level == 0) ? quiet + 1 : 0;
      end
      chk("drain_timeout", 64'(n >= 3000), 0);
   endtask

   task automatic compare(input string tag);
      while (exq.size() > 0) begin
         logic [44:0] e;
         e = exq.pop_front();
         if (rd_idx < rcv.size()) begin
            chk(tag, rcv[rd_idx], e);
            rd_idx++;
         end else chk({tag, "_missing"}, 1, 0);
      end
      chk({tag, "_extra"}, 64'(rcv.size() - rd_idx), 0);
   endtask

   // output monitor: captures accepted words, checks hold during stalls
   logic [44:0] mon_w, prev_w;
   bit prev_stall = 1'b0;
   initial forever begin
      @(negedge clk);
      mon_w = {mif.m_seq, mif.m_last, mif.m_chan, mif.m_data};
      if (prev_stall && mif.m_valid) begin
         hold_cnt++;
         if (mon_w !== prev_w) hold_bad++;
      end
      if (mif.m_valid && mif.m_ready) rcv.push_back(mon_w);
      prev_stall = mif.m_valid && !mif.m_ready;
      prev_w = mon_w;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [N*32-1:0] bus;
      bit              frc;
      int              hold;
      bit              exp_snap;
   } vec_t;
   vec_t tbl[6];

   initial begin
      logic [N*32-1:0] a, b, v;
      int n;
      tbl[0] = '{{32'd40, 32'd30, 32'd20, 32'd10}, 1'b0, 14, 1'b1};
      tbl[1] = '{{32'd40, 32'd30, 32'd20, 32'd10}, 1'b0, 14, 1'b0};
      tbl[2] = '{{32'd40, 32'd30, 32'd20, 32'd10}, 1'b1, 14, 1'b1};
      tbl[3] = '{{32'd8, 32'd7, 32'd6, 32'd5},     1'b0, 14, 1'b1};
      tbl[4] = '{{N*32{1'b0}},                     1'b0, 14, 1'b1};
      tbl[5] = '{{32'hFFFFFFFF, 32'd0, 32'd1, 32'hDEADBEEF}, 1'b0, 14, 1'b1};

      mif.m_ready = 1'b1;
      repeat (3) tick();
      chk("rst_valid", mif.m_valid, 0);
      chk("rst_data",  mif.m_data, 0);
      chk("rst_chan",  mif.m_chan, 0);
      chk("rst_last",  mif.m_last, 0);
      chk("rst_seq",   mif.m_seq, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_drop",  drop_count, 0);
      aresetn = 1'b1;
      repeat (6) tick();
      chk("idle_no_word", mif.m_valid, 0);

      // table: settle, steady, force and value changes
      for (int i = 0; i < 6; i++) begin
         freq_in = tbl[i].bus;
         if (tbl[i].frc) pulse();
         repeat (tbl[i].hold) tick();
         if (tbl[i].exp_snap) model_snap(tbl[i].bus);
      end
      drain(); compare("table");

      // bus toggling every cycle never settles; only the final value counts
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 20; i++) begin
         freq_in = i[0] ? b : a; tick();
      end
      freq_in = {32'd4, 32'd3, 32'd2, 32'd1};
      repeat (14) tick();
      model_value(freq_in);
      drain(); compare("toggle");

      // pulses while busy collapse into one pending capture
      pulse(); tick(); pulse(); pulse();
      repeat (25) tick();
      model_snap(freq_in); model_snap(freq_in);
      drain(); compare("pend_merge");

      // fill: 9 captures with consumer stalled, the 9th is dropped
      mif.m_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         pulse(); repeat (9) tick();
         if (i < 8) model_snap(freq_in);
         else begin m_seq = (m_seq + 1) % 256; m_drop++; end
      end
      chk("full_level", fifo_level, 32);
      chk("full_drop", drop_count, 16'(m_drop));
      chk("full_valid", mif.m_valid, 1);
      drain(); compare("full");

      // ready toggling during a write
      freq_in = {32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 40; i++) begin
         mif.m_ready = i[0]; tick();
      end
      model_value(freq_in);
      drain(); compare("stall");
      chk("hold_seen", 64'(hold_cnt > 0), 1);
      chk("hold_stable", hold_bad, 0);

      // reset in the middle of a write
      mif.m_ready = 1'b0;
      freq_in = {32'h5, 32'h6, 32'h7, 32'h8};
      n = 0;
      while (fifo_level != 2 && n < 40) begin tick(); n++; end
      chk("mid_write_reached", 64'(n >= 40), 0);
      aresetn = 1'b0; #1;
      chk("midrst_valid", mif.m_valid, 0);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_drop", drop_count, 0);
      exq.delete(); rd_idx = rcv.size();
      m_seq = 0; m_committed = '0; m_drop = 0;
      tick(); tick();
      aresetn = 1'b1;
      freq_in = {32'h9, 32'hA, 32'hB, 32'hC};
      repeat (20) tick();
      model_value(freq_in);
      drain(); compare("after_reset");

      // randomized: glitches, repeats and new values with random backpressure
      for (int it = 0; it < 25; it++) begin
         int g;
         g = $urandom_range(0, 3);
         for (int j = 0; j < g; j++) begin
            freq_in = {$urandom, $urandom, $urandom, $urandom};
            mif.m_ready = $urandom_range(0, 1); tick();
         end
         v = ($urandom_range(0, 3) == 0) ? m_committed : {$urandom, $urandom, $urandom, $urandom};
         freq_in = v;
         n = $urandom_range(12, 16);
         for (int j = 0; j < n; j++) begin
            mif.m_ready = $urandom_range(0, 1); tick();
         end
         model_value(v);
      end
      drain(); compare("random");
      chk("random_drop", drop_count, 0);

      // sequence wrap over 300 forced snapshots
      mif.m_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         pulse(); repeat (7) tick();
         model_snap(freq_in);
      end
      drain(); compare("wrap");
      chk("wrap_drop", drop_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
